// File: rtl/pgm_mem_reader_pkg.sv
// Shared types and constants for the RAM read-back engine.
// Imported by the interface, the engine and its bench.
package pgm_mem_reader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_WAIT,
      ST_CAPTURE,
      ST_DRAIN,
      ST_DONE
   } state_e;

   localparam int   DEFAULT_DEPTH   = 1024;
   localparam int   DEFAULT_RD_WAIT = 2;

   // Write strobe is active low; this engine only ever parks it inactive.
   localparam logic WRITE_IDLE = 1'b1;

   // Width of a counter holding 0..n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pgm_mem_reader_if.sv
// RAM bus plus captured-word stream of the read-back engine.
// master = the engine, slave = RAM model and downstream consumer.
interface pgm_mem_reader_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_read;
   logic              mem_write_n;
   logic              mem_oe;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;

   modport master (
      output mem_addr, mem_read, mem_write_n, mem_oe,
      output out_valid, out_data, out_addr,
      input  mem_data, out_ready
   );

   modport slave (
      input  mem_addr, mem_read, mem_write_n, mem_oe,
      input  out_valid, out_data, out_addr,
      output mem_data, out_ready
   );

endinterface

// File: rtl/pgm_mem_reader.sv
// Walks a window of RAM words and streams each one out with its address.
// One-entry holding register lets the next read overlap a stalled consumer.
module pgm_mem_reader
   import pgm_mem_reader_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = DEFAULT_DEPTH,
   parameter int RD_WAIT = DEFAULT_RD_WAIT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] word_count,
   output logic              busy,
   output logic              done,
   pgm_mem_reader_if.master  bus
);

   localparam int                WCW       = cnt_width(RD_WAIT);
   localparam logic [WCW-1:0]    WAIT_LAST = WCW'(RD_WAIT - 1);
   localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

   state_e            state, state_nxt;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] remaining;
   logic [WCW-1:0]    wait_cnt;
   logic [DATA_W-1:0] capture_q;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic [ADDR_W-1:0] out_addr_q;

   logic              accept_start;
   logic              load_beat;
   logic              capture_en;
   logic              take_beat;
   logic              slot_free;
   logic              wait_last;
   logic              rd_phase;

   // NOTE: state and datapath use <= so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path infers a latch.
      state_nxt    = state;
      accept_start = 1'b0;
      load_beat    = 1'b0;
      capture_en   = 1'b0;
      take_beat    = out_valid_q && bus.out_ready;
      slot_free    = !out_valid_q || bus.out_ready;
      wait_last    = (wait_cnt == WAIT_LAST);

      unique case (state)
         ST_IDLE: begin
            if (start) begin
               accept_start = 1'b1;
               state_nxt    = (word_count == '0) ? ST_DONE : ST_SETUP;
            end
         end
         ST_SETUP: state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (wait_last) begin
               capture_en = 1'b1;
               state_nxt  = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (slot_free) begin
               load_beat = 1'b1;
               state_nxt = (remaining == ONE) ? ST_DRAIN : ST_SETUP;
            end
         end
         ST_DRAIN: begin
            if (slot_free) state_nxt = ST_DONE;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase

      // Abort beats everything, including a start in the same cycle.
      if (abort) begin
         state_nxt    = ST_IDLE;
         accept_start = 1'b0;
         load_beat    = 1'b0;
         capture_en   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_addr    <= '0;
         remaining   <= '0;
         wait_cnt    <= '0;
         capture_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
      end else if (abort) begin
         cur_addr    <= '0;
         remaining   <= '0;
         wait_cnt    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (accept_start) begin
            cur_addr  <= base_addr & ADDR_MASK;
            remaining <= word_count;
         end

         if (state == ST_WAIT && !wait_last) wait_cnt <= wait_cnt + WCW'(1);
         else                                wait_cnt <= '0;

         if (capture_en) capture_q <= bus.mem_data;

         // Loading wins over draining: a handshake in the same cycle frees the slot.
         if (load_beat) begin
            out_data_q  <= capture_q;
            out_addr_q  <= cur_addr;
            out_valid_q <= 1'b1;
            cur_addr    <= (cur_addr + ONE) & ADDR_MASK;
            remaining   <= remaining - ONE;
         end else if (take_beat) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign rd_phase        = (state == ST_SETUP) || (state == ST_WAIT);
   assign busy            = (state != ST_IDLE);
   assign done            = (state == ST_DONE);

   assign bus.mem_addr    = cur_addr;
   assign bus.mem_read    = rd_phase;
   assign bus.mem_oe      = rd_phase;
   assign bus.mem_write_n = WRITE_IDLE;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
   assign bus.out_addr    = out_addr_q;

endmodule

// File: tb/tb_pgm_mem_reader.sv
// Randomized bench for pgm_mem_reader: RAM array, queue-based expected stream,
// handshake monitor and directed wrap/stall/abort/reset scenarios.
module tb_pgm_mem_reader;
   import pgm_mem_reader_pkg::*;

   localparam int AW       = 32;
   localparam int DW       = 32;
   localparam int DEPTH    = 1024;
   localparam int RD_WAIT  = 2;
   localparam int BEAT_GAP = RD_WAIT + 2;
   localparam int IW       = $clog2(DEPTH);

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } beat_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] word_count = '0;
   logic          busy;
   logic          done;
   logic          ready = 1'b1;

   pgm_mem_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   pgm_mem_reader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_WAIT(RD_WAIT)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .abort      (abort),
      .base_addr  (base_addr),
      .word_count (word_count),
      .busy       (busy),
      .done       (done),
      .bus        (bus.master)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] ram [DEPTH];
   assign bus.mem_data  = bus.mem_oe ? ram[bus.mem_addr[IW-1:0]] : 32'hDEAD_BEEF;
   assign bus.out_ready = ready;

   int    vectors = 0;
   int    miscompares = 0;
   int    cyc = 0;
   beat_t exp_q[$];
   logic  mon_en = 1'b0;
   logic  oe_allowed = 1'b0;
   logic  spacing_chk = 1'b0;
   logic  hold_pending = 1'b0;
   logic [DW-1:0] held_data;
   logic [AW-1:0] held_addr;
   int    done_cnt = 0;
   int    last_event = 0;
   int    beats_this_dump = 0;
   int    oe_cycles = 0;
   int    ready_mode = 0;   // 0: always ready, 1: random, 2: stalled

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       ready = 1'b1;
         1:       ready = 1'($urandom_range(0, 1));
         default: ready = 1'b0;
      endcase
   end

   always @(negedge clk) begin
      if (mon_en) begin
         beat_t e;
         check("write_n_high", bus.mem_write_n, 1);
         check("oe_only_in_dump", bus.mem_oe && !oe_allowed, 0);
         if (bus.mem_oe) oe_cycles++;
         if (hold_pending) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_data", bus.out_data, held_data);
            check("hold_addr", bus.out_addr, held_addr);
         end
         if (bus.out_valid && bus.out_ready) begin
            check("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("beat_addr", bus.out_addr, e.addr);
               check("beat_data", bus.out_data, e.data);
            end
            if (spacing_chk && beats_this_dump > 0)
               check("beat_gap", cyc - last_event, BEAT_GAP);
            beats_this_dump++;
            last_event = cyc;
         end
         hold_pending = bus.out_valid && !bus.out_ready && !abort;
         held_data    = bus.out_data;
         held_addr    = bus.out_addr;
         if (done) begin
            done_cnt++;
            check("done_one_after_last", cyc - last_event, 1);
            check("done_queue_empty", exp_q.size(), 0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected stream comes straight from the window rule: (base+i) mod DEPTH.
   task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] n, input logic gap_chk);
      exp_q.delete();
      for (int i = 0; i < int'(n); i++) begin
         int unsigned a;
         a = (int'(b) + i) % DEPTH;
         exp_q.push_back('{addr: AW'(a), data: ram[a]});
      end
      spacing_chk     = gap_chk;
      beats_this_dump = 0;
      oe_allowed      = (n != 0);
      base_addr       = b;
      word_count      = n;
      start           = 1'b1;
      last_event      = cyc;
      tick();
      start      = 1'b0;
      base_addr  = $urandom;
      word_count = $urandom;
   endtask

   task automatic wait_done(input int budget);
      int d0;
      int k;
      d0 = done_cnt;
      k  = 0;
      while (done_cnt == d0 && k < budget) begin
         tick();
         k++;
      end
      check("done_seen", done_cnt != d0, 1);
      check("busy_low_after_done", busy, 0);
      tick();
      check("done_single_pulse", done_cnt - d0, 1);
      oe_allowed = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int found;
      int d0;
      int oe0;

      for (int i = 0; i < DEPTH; i++) ram[i] = 32'hA500_0000 + i;

      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_read", bus.mem_read, 0);
      check("rst_mem_oe", bus.mem_oe, 0);
      check("rst_write_n", bus.mem_write_n, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_addr", bus.out_addr, 0);
      reset_n = 1'b1;
      tick();
      mon_en = 1'b1;

      // Basic 4-word dump at full rate.
      ready_mode = 0;
      launch(0, 4, 1);
      wait_done(100);

      // Window crossing the top of RAM.
      launch(1022, 4, 1);
      wait_done(100);

      // Empty window: done only, no RAM access, no beats.
      launch(0, 0, 0);
      wait_done(10);

      // Start coincident with abort in IDLE: abort wins.
      start = 1'b1; abort = 1'b1; base_addr = 40; word_count = 3;
      tick();
      start = 1'b0; abort = 1'b0;
      check("start_abort_idle", busy, 0);
      tick();
      check("start_abort_no_oe", bus.mem_oe, 0);

      // Consumer stalls 20 cycles after the second beat.
      launch(300, 6, 0);
      found = 0;
      while (beats_this_dump < 2 && found < 100) begin tick(); found++; end
      check("stall_reached", beats_this_dump, 2);
      ready_mode = 2;
      oe0 = oe_cycles;
      repeat (20) tick();
      check("stall_valid_held", bus.out_valid, 1);
      check("stall_addr", bus.out_addr, 302);
      check("stall_in_capture", bus.mem_oe, 0);
      check("stall_read_ahead", oe_cycles - oe0, 2 * RD_WAIT + 1);
      ready_mode = 0;
      wait_done(200);

      // Abort during WAIT of word 2.
      launch(100, 8, 0);
      found = 0;
      while (!(bus.mem_oe && bus.mem_addr == 102) && found < 100) begin tick(); found++; end
      check("abort_reach_word2", bus.mem_oe && bus.mem_addr == 102, 1);
      tick();
      d0 = done_cnt;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      exp_q.delete();
      oe_allowed = 1'b0;
      check("abort_beats_before", beats_this_dump, 2);
      check("abort_out_valid", bus.out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_oe", bus.mem_oe, 0);
      repeat (10) tick();
      check("abort_no_done", done_cnt - d0, 0);
      launch(7, 3, 1);
      wait_done(100);

      // Asynchronous reset with a word pending downstream.
      ready_mode = 2;
      launch(200, 5, 0);
      found = 0;
      while (!bus.out_valid && found < 50) begin tick(); found++; end
      check("reset_valid_pending", bus.out_valid, 1);
      @(negedge clk);
      mon_en = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_out_valid", bus.out_valid, 0);
      check("arst_out_data", bus.out_data, 0);
      check("arst_out_addr", bus.out_addr, 0);
      check("arst_mem_addr", bus.mem_addr, 0);
      check("arst_mem_oe", bus.mem_oe, 0);
      check("arst_mem_read", bus.mem_read, 0);
      check("arst_write_n", bus.mem_write_n, 1);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      exp_q.delete();
      hold_pending = 1'b0;
      oe_allowed   = 1'b0;
      ready_mode   = 0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      check("post_reset_idle", busy, 0);
      mon_en = 1'b1;

      // Random data, windows, backpressure, and starts issued while busy.
      for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
      ready_mode = 1;
      for (int t = 0; t < 10; t++) begin
         logic [AW-1:0] b;
         logic [AW-1:0] n;
         b = AW'($urandom_range(0, DEPTH - 1));
         n = AW'($urandom_range(1, 12));
         launch(b, n, 0);
         repeat ($urandom_range(0, 6)) tick();
         if (busy) begin
            start = 1'b1;
            base_addr = $urandom;
            word_count = AW'($urandom_range(1, 20));
            tick();
            start = 1'b0;
         end
         wait_done(int'(n) * 40 + 100);
      end

      // Window longer than RAM rereads from the base.
      ready_mode = 0;
      launch(5, DEPTH + 3, 1);
      wait_done((DEPTH + 3) * BEAT_GAP + 50);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
